dma_burst_engine: RTL and testbench

- Parametrised successor to the single-shot 3-block DMA.
- Accepts a descriptor: base address plus block count, requested with a one-cycle cmd pulse.
- Arbitrates for the shared memory bus via BR/BG and writes N device blocks of BLOCK_WORDS words each, holding every write for WRITE_LATENCY cycles.
- Optionally yields the bus between blocks for cycle stealing, tolerates grant preemption, and raises a one-cycle interrupt on completion.

---
 rtl/dma_burst_engine.sv | 143 ++++++++++++++
 tb/tb_dma_burst_engine.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_burst_engine.sv
// rtl/dma_burst_engine.sv - descriptor-driven multi-block DMA with BR/BG bus arbitration
// Writes up to MAX_BLOCKS device blocks per command, optionally yielding the bus between blocks.
module dma_burst_engine #(
    parameter int WORD_SIZE     = 16,
    parameter int BLOCK_WORDS   = 4,
    parameter int MAX_BLOCKS    = 4,
    parameter int WRITE_LATENCY = 4,
    parameter bit STEAL_EN      = 1'b1,
    localparam int OFFSET_W     = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1,
    localparam int DATA_W       = BLOCK_WORDS * WORD_SIZE
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 cmd,
    input  logic [WORD_SIZE-1:0] cmd_addr,
    input  logic [OFFSET_W:0]    cmd_len,
    input  logic                 BG,
    input  logic [DATA_W-1:0]    edata,
    output logic                 BR,
    output wire                  WRITE,
    output wire [WORD_SIZE-1:0]  addr,
    output wire [DATA_W-1:0]     data,
    output logic [OFFSET_W-1:0]  offset,
    output logic                 busy,
    output logic                 interrupt
);

    localparam int LAT_W = (WRITE_LATENCY > 1) ? $clog2(WRITE_LATENCY) : 1;
    localparam logic [LAT_W-1:0]    LAT_LAST = LAT_W'(WRITE_LATENCY - 1);
    localparam logic [OFFSET_W:0]   LEN_MAX  = (OFFSET_W + 1)'(MAX_BLOCKS);
    localparam logic [OFFSET_W:0]   LEN_ONE  = (OFFSET_W + 1)'(1);
    localparam logic [OFFSET_W-1:0] BLK_ONE  = OFFSET_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_YIELD,
        S_DONE
    } state_t;

    state_t                 state_q;
    logic                   br_q;
    logic                   busy_q;
    logic                   irq_q;
    logic [OFFSET_W-1:0]    blk_q;
    logic [LAT_W-1:0]       lat_q;
    logic [WORD_SIZE-1:0]   base_q;
    logic [OFFSET_W:0]      len_q;

    logic [OFFSET_W:0]      len_clamped;
    logic                   last_blk;
    logic                   drive;
    logic [WORD_SIZE-1:0]   blk_addr;

    assign len_clamped = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
    assign last_blk    = ({1'b0, blk_q} == (len_q - LEN_ONE));
    assign blk_addr    = base_q + WORD_SIZE'(blk_q) * WORD_SIZE'(BLOCK_WORDS);

    // Bus ownership follows the live grant so a preemption releases the bus in the same cycle.
    assign drive = (state_q == S_XFER) && BG;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            br_q    <= 1'b0;
            busy_q  <= 1'b0;
            irq_q   <= 1'b0;
            blk_q   <= '0;
            lat_q   <= '0;
            base_q  <= '0;
            len_q   <= '0;
        end else begin
            irq_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd) begin
                        blk_q  <= '0;
                        lat_q  <= '0;
                        busy_q <= 1'b1;
                        if (cmd_len == '0) begin
                            irq_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            base_q  <= cmd_addr;
                            len_q   <= len_clamped;
                            br_q    <= 1'b1;
                            state_q <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (BG) begin
                        lat_q   <= '0;
                        state_q <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (!BG) begin
                        // Preempted: the current block restarts from its first cycle.
                        lat_q   <= '0;
                        state_q <= S_REQ;
                    end else if (lat_q == LAT_LAST) begin
                        lat_q <= '0;
                        if (last_blk) begin
                            br_q    <= 1'b0;
                            irq_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            blk_q <= blk_q + BLK_ONE;
                            if (STEAL_EN) begin
                                br_q    <= 1'b0;
                                state_q <= S_YIELD;
                            end
                        end
                    end else begin
                        lat_q <= lat_q + LAT_W'(1);
                    end
                end
                S_YIELD: begin
                    if (!BG) begin
                        br_q    <= 1'b1;
                        state_q <= S_REQ;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign BR        = br_q;
    assign busy      = busy_q;
    assign interrupt = irq_q;
    assign offset    = blk_q;
    assign WRITE     = drive ? 1'b1 : 1'bz;
    assign addr      = drive ? blk_addr : {WORD_SIZE{1'bz}};
    assign data      = drive ? edata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_dma_burst_engine.sv
// tb/tb_dma_burst_engine.sv - table-driven, hand-written and randomized checks for dma_burst_engine
module tb_dma_burst_engine;

    localparam int WS = 16;
    localparam int WL = 4;
    localparam int MB = 4;
    localparam int OW = 2;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          cmd_v   [2];
    logic [WS-1:0] caddr_v [2];
    logic [OW:0]   clen_v  [2];
    logic          bg_v    [2];
    logic [DW-1:0] edata_v [2];

    wire          write0, write1;
    wire [WS-1:0] addr0, addr1;
    wire [DW-1:0] data0, data1;
    wire          br0, br1, busy0, busy1, irq0, irq1;
    wire [OW-1:0] off0, off1;

    logic          wr_v   [2];
    logic [WS-1:0] addr_v [2];
    logic [DW-1:0] data_v [2];
    logic          br_v   [2];
    logic          busy_v [2];
    logic          irq_v  [2];
    logic [OW-1:0] off_v  [2];

    assign wr_v[0] = write0;   assign wr_v[1] = write1;
    assign addr_v[0] = addr0;  assign addr_v[1] = addr1;
    assign data_v[0] = data0;  assign data_v[1] = data1;
    assign br_v[0] = br0;      assign br_v[1] = br1;
    assign busy_v[0] = busy0;  assign busy_v[1] = busy1;
    assign irq_v[0] = irq0;    assign irq_v[1] = irq1;
    assign off_v[0] = off0;    assign off_v[1] = off1;

    dma_burst_engine u_steal (
        .CLK(clk), .RESET(rst), .cmd(cmd_v[0]), .cmd_addr(caddr_v[0]), .cmd_len(clen_v[0]),
        .BG(bg_v[0]), .edata(edata_v[0]), .BR(br0), .WRITE(write0), .addr(addr0), .data(data0),
        .offset(off0), .busy(busy0), .interrupt(irq0)
    );

    dma_burst_engine #(.STEAL_EN(1'b0)) u_b2b (
        .CLK(clk), .RESET(rst), .cmd(cmd_v[1]), .cmd_addr(caddr_v[1]), .cmd_len(clen_v[1]),
        .BG(bg_v[1]), .edata(edata_v[1]), .BR(br1), .WRITE(write1), .addr(addr1), .data(data1),
        .offset(off1), .busy(busy1), .interrupt(irq1)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // mode: 0 BG follows BR, 1 random BG, 2 BG held high, 3 follow + preempt block 1, 4 follow + stray cmds
    typedef struct {
        int          sel;
        logic [15:0] a;
        logic [2:0]  len;
        int          mode;
        int          e_blk;
        int          e_wr;
        int          e_busy;
        int          e_br;
        logic [15:0] e_last;
    } row_t;

    row_t rows [8];

    // Scoreboard: every write cycle must belong to the next unfinished block; a block counts
    // as done after WL consecutive write cycles, shorter runs are restarts of the same block.
    task automatic run_desc(input int sel, input logic [15:0] a, input logic [2:0] len, input int mode,
                            output int nblk, output int nwr, output int nbusy, output int nbr,
                            output int nirq, output logic [15:0] last_a);
        logic [DW-1:0] ed;
        logic [15:0]   ea;
        int            seg, force_cnt;
        bit            started, forced_done, forced_now, bg;
        ed = {$urandom, $urandom};
        nblk = 0; nwr = 0; nbusy = 0; nbr = 0; nirq = 0; last_a = '0;
        seg = 0; force_cnt = 0; started = 0; forced_done = 0;
        @(negedge clk);
        cmd_v[sel] = 1'b1; caddr_v[sel] = a; clen_v[sel] = len; edata_v[sel] = ed;
        bg_v[sel] = (mode == 2);
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            cmd_v[sel] = 1'b0;
            if (mode == 4 && cyc == 5) begin
                cmd_v[sel] = 1'b1; caddr_v[sel] = 16'h7777; clen_v[sel] = 3'd1;
            end
            case (mode)
                1:       bg = ($urandom_range(0, 7) != 0);
                2:       bg = 1'b1;
                default: bg = br_v[sel];
            endcase
            forced_now = (force_cnt > 0);
            if (forced_now) begin
                bg = 1'b0;
                force_cnt--;
            end
            bg_v[sel] = bg;
            #1;
            if (forced_now) chk("br_held_in_preempt", br_v[sel], 1);
            if (busy_v[sel]) begin
                started = 1;
                nbusy++;
            end
            if (br_v[sel]) nbr++;
            if (irq_v[sel]) nirq++;
            if (wr_v[sel] === 1'b1) begin
                nwr++;
                ea = a + 16'(nblk * 4);
                chk("write_needs_grant", bg, 1);
                chk("offset", off_v[sel], nblk);
                chk("addr", addr_v[sel], ea);
                chk("data", data_v[sel], ed);
                seg++;
                if (seg == WL) begin
                    nblk++;
                    seg = 0;
                    last_a = ea;
                end
                if (mode == 3 && !forced_done && nblk == 1 && seg == 1) begin
                    force_cnt = 3;
                    forced_done = 1;
                end
            end else begin
                seg = 0;
            end
            if (mode == 4 && irq_v[sel]) cmd_v[sel] = 1'b1;
            if (started && !busy_v[sel]) break;
        end
        chk("run_completed", (started && !busy_v[sel]) ? 1 : 0, 1);
        repeat (2) @(negedge clk);
        #1;
        chk("idle_busy_low", busy_v[sel], 0);
        chk("idle_br_low", br_v[sel], 0);
    endtask

    task automatic apply_row(input int r);
        int nblk, nwr, nbusy, nbr, nirq;
        logic [15:0] last_a;
        run_desc(rows[r].sel, rows[r].a, rows[r].len, rows[r].mode, nblk, nwr, nbusy, nbr, nirq, last_a);
        chk($sformatf("row%0d_blocks", r), nblk, rows[r].e_blk);
        chk($sformatf("row%0d_write_cycles", r), nwr, rows[r].e_wr);
        chk($sformatf("row%0d_busy_cycles", r), nbusy, rows[r].e_busy);
        chk($sformatf("row%0d_br_cycles", r), nbr, rows[r].e_br);
        chk($sformatf("row%0d_irq_pulses", r), nirq, 1);
        chk($sformatf("row%0d_last_addr", r), last_a, rows[r].e_last);
    endtask

    initial begin
        int cnt, nblk, nwr, nbusy, nbr, nirq, eblk, sel;
        logic [15:0] last_a, a, elast;
        logic [2:0]  len;

        rows[0] = '{0, 16'h01F4, 3'd3, 0, 3, 12, 18, 15, 16'h01FC};
        rows[1] = '{1, 16'h0100, 3'd4, 2, 4, 16, 18, 17, 16'h010C};
        rows[2] = '{0, 16'hFFFC, 3'd2, 0, 2,  8, 12, 10, 16'h0000};
        rows[3] = '{0, 16'h0040, 3'd0, 0, 0,  0,  1,  0, 16'h0000};
        rows[4] = '{0, 16'h1000, 3'd7, 0, 4, 16, 24, 20, 16'h100C};
        rows[5] = '{1, 16'h2000, 3'd1, 0, 1,  4,  6,  5, 16'h2000};
        rows[6] = '{0, 16'h0300, 3'd2, 3, 2,  9, 17, 15, 16'h0304};
        rows[7] = '{0, 16'h0500, 3'd3, 4, 3, 12, 18, 15, 16'h0508};

        for (int i = 0; i < 2; i++) begin
            cmd_v[i] = 1'b0; caddr_v[i] = '0; clen_v[i] = '0; bg_v[i] = 1'b0; edata_v[i] = '0;
        end

        #12;
        for (int i = 0; i < 2; i++) begin
            chk("reset_br", br_v[i], 0);
            chk("reset_busy", busy_v[i], 0);
            chk("reset_irq", irq_v[i], 0);
            chk("reset_offset", off_v[i], 0);
            chk("reset_write_released", (wr_v[i] === 1'b1) ? 1 : 0, 0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int r = 0; r < 8; r++) apply_row(r);

        // Asynchronous reset while block 1 is being written.
        @(negedge clk);
        cmd_v[0] = 1'b1; caddr_v[0] = 16'h0A00; clen_v[0] = 3'd3; edata_v[0] = {$urandom, $urandom};
        bg_v[0] = 1'b0;
        cnt = 0;
        for (int i = 0; i < 100 && cnt < 2; i++) begin
            @(negedge clk);
            cmd_v[0] = 1'b0;
            bg_v[0] = br_v[0];
            #1;
            if (wr_v[0] === 1'b1 && off_v[0] == 2'd1) cnt++;
        end
        chk("reached_block1", cnt, 2);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_br", br_v[0], 0);
        chk("async_rst_busy", busy_v[0], 0);
        chk("async_rst_irq", irq_v[0], 0);
        chk("async_rst_offset", off_v[0], 0);
        chk("async_rst_write_released", (wr_v[0] === 1'b1) ? 1 : 0, 0);
        @(negedge clk);
        rst = 1'b0;
        bg_v[0] = 1'b0;
        apply_row(0);

        // Randomized descriptors and grant behaviour against the arithmetic expectation.
        for (int t = 0; t < 20; t++) begin
            sel = $urandom_range(0, 1);
            a = 16'($urandom);
            len = 3'($urandom_range(0, 7));
            eblk = (len > MB) ? MB : int'(len);
            elast = (eblk > 0) ? a + 16'((eblk - 1) * 4) : 16'h0000;
            run_desc(sel, a, len, 1, nblk, nwr, nbusy, nbr, nirq, last_a);
            chk("rand_blocks", nblk, eblk);
            chk("rand_irq_pulses", nirq, 1);
            chk("rand_last_addr", last_a, elast);
            chk("rand_min_writes", (nwr >= eblk * WL) ? 1 : 0, 1);
            if (eblk == 0) chk("rand_len0_no_br", nbr, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
